// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter: parity modes, FSM encoding
// and the frame-length arithmetic used by the RTL and its bench.
package serial_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } tx_state_t;

  // Bits on the line for one character: start + data + optional parity + stop.
  function automatic int frame_bits(input int data_w, input int parity, input int stop_bits);
    return 1 + data_w + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

  function automatic int frame_cycles(input int data_w, input int parity,
                                      input int stop_bits, input int clks_per_bit);
    return frame_bits(data_w, parity, stop_bits) * clks_per_bit;
  endfunction

endpackage

// File: rtl/serial_fifo.sv
// Synchronous FIFO holding characters waiting to be framed; a write while full
// and a pop while empty are both ignored.
module serial_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             wr_fire;
  logic             pop_fire;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign rd_data  = mem_q[rd_ptr_q];
  assign wr_fire  = wr_en && !full;
  assign pop_fire = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_fire) rd_ptr_d = rd_ptr_q + AW'(1);
    if (wr_fire && !pop_fire) count_d = count_q + CW'(1);
    else if (pop_fire && !wr_fire) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/serial_tx.sv
// UART-style transmitter: queued characters are sent LSB-first as
// start / data / optional parity / stop framed bits.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_enable,
  input  logic [DATA_W-1:0]             tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          serial_out,
  output logic                          busy,
  output logic                          char_sent,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int TW         = $clog2(CLKS_PER_BIT);
  localparam int FRAME_BITS = frame_bits(DATA_W, PARITY, STOP_BITS);
  localparam int BW         = $clog2(FRAME_BITS);

  tx_state_t         state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic              serial_out_q, serial_out_d;
  logic              busy_q, busy_d;
  logic              char_sent_q, char_sent_d;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_pop;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              wrap;
  logic              start_frame;

  assign tx_ready = !fifo_full;

  serial_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (tx_valid && tx_ready),
    .wr_data (tx_data),
    .pop     (fifo_pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // bit_cnt_q indexes the bit within the frame: 0 is the start bit.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    parity_d    = parity_q;
    char_sent_d = 1'b0;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
    wrap        = (timer_q == TW'(CLKS_PER_BIT - 1));

    if (state_q != ST_IDLE) timer_d = wrap ? '0 : timer_q + TW'(1);

    case (state_q)
      ST_IDLE: begin
        if (tx_enable && !fifo_empty) start_frame = 1'b1;
      end
      ST_START: begin
        if (wrap) begin
          state_d   = ST_DATA;
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (wrap) begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_W)) state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
          else shift_d = shift_q >> 1;
        end
      end
      ST_PAR: begin
        if (wrap) begin
          state_d   = ST_STOP;
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      ST_STOP: begin
        if (wrap) begin
          if (bit_cnt_q == BW'(FRAME_BITS - 1)) begin
            char_sent_d = 1'b1;
            state_d     = ST_IDLE;
            if (tx_enable && !fifo_empty) start_frame = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Starting from the last stop bit chains frames with no idle gap.
    if (start_frame) begin
      fifo_pop  = 1'b1;
      state_d   = ST_START;
      timer_d   = '0;
      bit_cnt_d = '0;
      shift_d   = fifo_rd_data;
      parity_d  = (PARITY == PAR_ODD) ? ~(^fifo_rd_data) : (^fifo_rd_data);
    end

    case (state_d)
      ST_START: serial_out_d = 1'b0;
      ST_DATA:  serial_out_d = shift_d[0];
      ST_PAR:   serial_out_d = parity_d;
      default:  serial_out_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      serial_out_q <= 1'b1;
      busy_q       <= 1'b0;
      char_sent_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      serial_out_q <= serial_out_d;
      busy_q       <= busy_d;
      char_sent_q  <= char_sent_d;
    end
  end

  assign serial_out = serial_out_q;
  assign busy       = busy_q;
  assign char_sent  = char_sent_q;

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: three parity/stop configurations share one stimulus
// stream and are compared every cycle against a queue-based line model.
module tb_serial_tx;
  import serial_pkg::*;

  localparam int NDUT  = 3;
  localparam int CLKS  = 16;
  localparam int DEPTH = 4;
  localparam int P [NDUT] = '{0, 1, 2};
  localparam int S [NDUT] = '{1, 1, 2};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       tx_enable = 1'b0;
  logic       tx_valid  = 1'b0;
  logic [7:0] tx_data   = '0;

  logic       so  [NDUT];
  logic       bz  [NDUT];
  logic       cs  [NDUT];
  logic       rdy [NDUT];
  logic [2:0] cnt [NDUT];

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d0 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[0]), .serial_out(so[0]), .busy(bz[0]), .char_sent(cs[0]), .fifo_count(cnt[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) d1 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[1]), .serial_out(so[1]), .busy(bz[1]), .char_sent(cs[1]), .fifo_count(cnt[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(CLKS), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) d2 (
    .clk(clk), .rst(rst), .tx_enable(tx_enable), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy[2]), .serial_out(so[2]), .busy(bz[2]), .char_sent(cs[2]), .fifo_count(cnt[2]));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per DUT: queued characters, the character on the line and the cycle
  // offset into its frame. Line level follows from offset / CLKS.
  logic [7:0] exp_q [NDUT][$];
  logic [7:0] m_cur    [NDUT];
  int         m_pos    [NDUT];
  bit         m_active [NDUT];
  bit         m_sent   [NDUT];

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      m_cur[i] = '0; m_pos[i] = 0; m_active[i] = 1'b0; m_sent[i] = 1'b0;
    end
  end

  function automatic int flen(input int i);
    return frame_cycles(8, P[i], S[i], CLKS);
  endfunction

  function automatic logic exp_level(input int i);
    int b;
    logic [7:0] d;
    if (!m_active[i]) return 1'b1;
    b = m_pos[i] / CLKS;
    d = m_cur[i];
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (P[i] != 0 && b == 9) return (P[i] == 1) ? (^d) : ~(^d);
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    bit can_wr;
    if (!rst) begin
      for (int i = 0; i < NDUT; i++) begin
        exp_q[i].delete();
        m_active[i] = 1'b0; m_pos[i] = 0; m_sent[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        can_wr = (exp_q[i].size() < DEPTH);
        m_sent[i] = 1'b0;
        if (m_active[i]) begin
          if (m_pos[i] == flen(i) - 1) begin
            m_sent[i] = 1'b1;
            m_active[i] = 1'b0;
          end else begin
            m_pos[i]++;
          end
        end
        if (!m_active[i] && tx_enable && exp_q[i].size() > 0) begin
          m_cur[i] = exp_q[i].pop_front();
          m_pos[i] = 0;
          m_active[i] = 1'b1;
        end
        if (tx_valid && can_wr) exp_q[i].push_back(tx_data);
      end
    end
  end

  // Scoreboard: every output of every DUT, one time unit after each edge.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      for (int i = 0; i < NDUT; i++) begin
        check_eq($sformatf("serial_out%0d", i), 16'(so[i]), 16'(exp_level(i)));
        check_eq($sformatf("busy%0d", i), 16'(bz[i]), 16'(m_active[i]));
        check_eq($sformatf("char_sent%0d", i), 16'(cs[i]), 16'(m_sent[i]));
        check_eq($sformatf("fifo_count%0d", i), 16'(cnt[i]), 16'(exp_q[i].size()));
        check_eq($sformatf("tx_ready%0d", i), 16'(rdy[i]), 16'(exp_q[i].size() < DEPTH));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle_cycles(2);
    chk_en = 1'b1;
    idle_cycles(2);
    rst = 1'b1;
    idle_cycles(2);

    // Single 8'h99 through all three framings.
    tx_enable = 1'b1;
    write_byte(8'h99);
    idle_cycles(220);

    // Fill while disabled: fifth write refused, then drain back-to-back.
    tx_enable = 1'b0;
    for (int k = 1; k <= 5; k++) write_byte(8'(k));
    idle_cycles(10);
    tx_enable = 1'b1;
    idle_cycles(4 * 192 + 40);

    // Two frames back to back (two stop bits on d2).
    write_byte(8'hA5);
    write_byte(8'h3C);
    idle_cycles(2 * 192 + 40);

    // Disable during data bit 3 of the first frame; rest stays queued.
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    idle_cycles(68);
    tx_enable = 1'b0;
    idle_cycles(260);
    tx_enable = 1'b1;
    idle_cycles(2 * 192 + 40);

    // Random traffic with occasional enable toggles.
    for (int k = 0; k < 1500; k++) begin
      tx_valid = ($urandom_range(0, 9) < 2);
      tx_data  = 8'($urandom);
      if ($urandom_range(0, 99) == 0) tx_enable = ~tx_enable;
      @(negedge clk);
    end
    tx_valid  = 1'b0;
    tx_enable = 1'b1;
    idle_cycles(4 * 192 + 200);

    // Reset during data bit 5 with characters still queued.
    write_byte(8'h5A);
    write_byte(8'h6B);
    write_byte(8'h7C);
    idle_cycles(100);
    rst = 1'b0;
    #1;
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("rst_serial_out%0d", i), 16'(so[i]), 16'd1);
      check_eq($sformatf("rst_busy%0d", i), 16'(bz[i]), 16'd0);
      check_eq($sformatf("rst_fifo_count%0d", i), 16'(cnt[i]), 16'd0);
      check_eq($sformatf("rst_char_sent%0d", i), 16'(cs[i]), 16'd0);
      check_eq($sformatf("rst_tx_ready%0d", i), 16'(rdy[i]), 16'd1);
    end
    idle_cycles(3);
    rst = 1'b1;
    idle_cycles(60);
    write_byte(8'hC3);
    idle_cycles(220);

    chk_en = 1'b0;
    idle_cycles(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
# serial_tx

Parametrised UART-style serial transmitter for the board-to-board link. Bytes are queued through a valid/ready handshake into a small FIFO and sent LSB-first as framed characters: start bit, data, optional parity, then one or two stop bits. A built-in bit-interval counter replaces the separate bit/sample counter blocks. The 10-bit shift-register path becomes a single block with configurable width, parity and stop bits.

## Interface
- DATA_W, 8, data bits per character (5–9)
- CLKS_PER_BIT, 16, clk cycles per serial bit (≥2)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 4, queued characters (power of 2, ≥2)

Ports:
- clk  in  1  rising-edge clock, single clock domain
- rst  in  1  asynchronous, active-low reset
- tx_enable  in  1  permits starting new frames
- tx_data  in  DATA_W  character to queue
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  FIFO can accept (= !full)
- serial_out  out  1  line output, idles high
- busy  out  1  frame in progress
- char_sent  out  1  one-cycle pulse when a frame's last stop bit completes
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued, excluding the frame in flight

## Operation
- Write: the FIFO is written on a rising edge with tx_valid && tx_ready. When the FIFO is full, tx_valid is ignored and the FIFO is unchanged.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE → START: when tx_enable is high and the FIFO is non-empty.
  - The FIFO is popped.
  - The shift register is loaded.
  - Parity is computed: even = XOR of the data bits, odd = its inverse.
- Line level per state:
  - START drives 0.
  - DATA drives bits LSB first, DATA_W bits.
  - PAR drives the parity bit; the state is skipped when PARITY = 0.
  - STOP drives 1 for STOP_BITS bit times.
- Bit timer: each bit lasts exactly CLKS_PER_BIT cycles. The timer runs 0..CLKS_PER_BIT-1 and the state or bit advances at wrap.
- End of last stop bit:
  - char_sent pulses.
  - If tx_enable is high and the FIFO is non-empty, go straight to START, so there is no idle gap between frames.
  - Otherwise go to IDLE.
- tx_enable low mid-frame: the current frame completes normally and no new frame starts.
- Simultaneous write and pop with the FIFO full: the write is refused, since tx_ready is low.
- Simultaneous write and pop with the FIFO otherwise: both occur and fifo_count is unchanged.
- busy is high in every state except IDLE.

## Timing
- Reset values: serial_out = 1, tx_ready = 1, busy = 0, char_sent = 0, fifo_count = 0. FSM = IDLE, FIFO empty, timer = 0.
- Reset asserted mid-frame: the frame is aborted immediately, serial_out returns to 1 and the FIFO contents are discarded.
- All outputs are registered except tx_ready, which is decoded from the registered count.
- Latency: a character accepted at edge E into an empty FIFO while IDLE and enabled gives START at edge E+1. serial_out goes low after E+1.
- Frame length: (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles.
- char_sent: high for the single cycle after the final stop-bit edge, coincident with busy falling or with the next START.

## Structure
- Package serial_pkg holds:
  - parity constants PAR_NONE/PAR_EVEN/PAR_ODD
  - the FSM state encoding
  - a frame-length function used by RTL and bench
- Sub-module serial_fifo: synchronous FIFO with write/pop, full, empty and count, parametrised on width and depth.
- The FSM, bit timer and shift register live in serial_tx.

## Test plan
- Default parameters, 8'h99 sent once → serial_out reads 0,1,0,0,1,1,0,0,1,1, each level lasting 16 cycles. char_sent pulses 160 cycles after the start bit begins.
- PARITY = 1, then PARITY = 2, with 8'h99 → parity bit 0 (even), then 1 (odd). Frame length 176 cycles.
- tx_enable low, 5 writes of 8'h01..8'h05 with FIFO_DEPTH = 4 → tx_ready drops after the 4th write and fifo_count = 4. Raising tx_enable sends 01..04 back-to-back with no idle high between the stop and start bits; 05 is never sent.
- STOP_BITS = 2, 8'hA5 → stop level high for 32 cycles; the next queued frame starts immediately after.
- tx_enable dropped during data bit 3 → the frame finishes intact, busy falls, and the queued characters remain in the FIFO.
- rst asserted during data bit 5 → serial_out = 1, busy = 0 and fifo_count = 0 at once. After release the line idles high until a new write.
